// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register interface.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h48;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into the clk domain and flags SCL edges plus START/STOP.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl_now;

  assign scl_now = scl_sync[SYNC_STAGES-1];
  assign sda_s   = sda_sync[SYNC_STAGES-1];

  // Synchronizer chains plus one history register for edge detection; idle bus is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_q    <= scl_now;
      sda_q    <= sda_s;
    end
  end

  // START/STOP require SCL high on both sides of the SDA transition.
  assign scl_rise  =  scl_now & ~scl_q;
  assign scl_fall  = ~scl_now &  scl_q;
  assign start_det =  scl_now &  scl_q &  sda_q & ~sda_s;
  assign stop_det  =  scl_now &  scl_q & ~sda_q &  sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target exposing an 8-bit register map through a strobe interface.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       reg_re,
  output logic       busy
);

  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       sda_s;

  i2c_state_t state;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic       rw;
  logic       ack_phase;
  logic [7:0] byte_in;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_s    (sda_s)
  );

  assign byte_in = {shift[6:0], sda_s};

  // Protocol FSM: bus conditions first, then the TX load, then SCL-edge driven bit handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 8'h00;
      rw        <= RW_WRITE;
      ack_phase <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= 4'd0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
      end else begin
        // reg_rdata is valid during the reg_re cycle; capture it and present bit 7.
        if (reg_re) begin
          shift  <= reg_rdata;
          sda_oe <= ~reg_rdata[7];
        end
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (byte_in[7:1] == TARGET_ADDR) begin
                  state     <= ADDR_ACK;
                  busy      <= 1'b1;
                  rw        <= byte_in[0];
                  ack_phase <= 1'b0;
                end else begin
                  state <= IGNORE;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= 4'd0;
                if (rw == RW_READ) begin
                  // ACK stays driven until the first read bit is loaded next clk.
                  reg_re <= 1'b1;
                  state  <= RDATA;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= PTR;
                end
              end
            end
          end
          PTR: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                reg_addr  <= byte_in;
                state     <= PTR_ACK;
                ack_phase <= 1'b0;
              end
            end
          end
          PTR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
                bit_cnt   <= 4'd0;
                state     <= WDATA;
              end
            end
          end
          WDATA: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                reg_wdata <= byte_in;
                reg_we    <= 1'b1;
                state     <= WDATA_ACK;
                ack_phase <= 1'b0;
              end
            end
          end
          WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
                bit_cnt   <= 4'd0;
                reg_addr  <= reg_addr + 8'd1;
                state     <= WDATA;
              end
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
                state     <= RDATA_ACK;
              end else begin
                sda_oe <= ~shift[6];
                shift  <= {shift[6:0], 1'b0};
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_s == I2C_ACK) begin
                reg_addr  <= reg_addr + 8'd1;
                ack_phase <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                state  <= IGNORE;
              end
            end else if (scl_fall && ack_phase) begin
              reg_re    <= 1'b1;
              bit_cnt   <= 4'd0;
              ack_phase <= 1'b0;
              state     <= RDATA;
            end
          end
          IDLE, IGNORE: begin
            sda_oe <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Randomized bench for i2c_target: a bus initiator, a register file, and a
// transaction-level model of register contents and pointer.
module tb_i2c_target;

  localparam int SYNC_STAGES = 2;

  logic       clk;
  logic       rst;
  logic       m_scl;
  logic       m_sda;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic [7:0] reg_rdata;
  logic       reg_re;
  logic       busy;

  logic [7:0] mem [256];
  logic [7:0] model_mem [256];
  logic [7:0] model_ptr;

  int total;
  int bad;
  int we_cnt;
  int re_cnt;
  int oe_cnt;
  int viol;
  logic [7:0] last_we_addr;
  logic [7:0] last_we_data;
  logic       oe_prev;

  assign sda_line  = m_sda & ~sda_oe;
  assign reg_rdata = mem[reg_addr];

  i2c_target #(
    .TARGET_ADDR(7'h48),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (m_scl),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_rdata(reg_rdata),
    .reg_re   (reg_re),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file behind the strobe interface, plus activity monitors.
  initial begin
    we_cnt = 0; re_cnt = 0; oe_cnt = 0; viol = 0;
    oe_prev = 1'b0;
    last_we_addr = 8'h00; last_we_data = 8'h00;
  end

  always @(posedge clk) begin
    if (reg_we) begin
      mem[reg_addr] <= reg_wdata;
      last_we_addr  <= reg_addr;
      last_we_data  <= reg_wdata;
      we_cnt        <= we_cnt + 1;
    end
    if (reg_re) re_cnt <= re_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (!rst && m_scl && (sda_oe !== oe_prev)) viol <= viol + 1;
    oe_prev <= sda_oe;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; #25;
    m_scl = 1'b1; #25;
    m_sda = 1'b0; #25;
    m_scl = 1'b0; #25;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #25;
    m_scl = 1'b1; #25;
    m_sda = 1'b1; #35;
    chk("busy_after_stop", busy, 1'b0);
    #15;
  endtask

  task automatic bit_cycle(input logic b, output logic seen);
    m_sda = b;    #25;
    m_scl = 1'b1; #25;
    seen = sda_line;
    #25;
    m_scl = 1'b0; #25;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, ack);
  endtask

  task automatic recv_byte(input logic m_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      d[i] = s;
    end
    bit_cycle(m_ack, s);
  endtask

  task automatic do_write(input logic [7:0] addr, input int n);
    logic ack;
    logic [7:0] d;
    i2c_start();
    send_byte(8'h90, ack); chk("wr_addr_ack", ack, 1'b0);
    send_byte(addr, ack);  chk("wr_ptr_ack", ack, 1'b0);
    model_ptr = addr;
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      send_byte(d, ack); chk("wr_data_ack", ack, 1'b0);
      model_mem[model_ptr] = d;
      model_ptr = model_ptr + 8'd1;
    end
    i2c_stop();
    chk("wr_ptr_end", reg_addr, model_ptr);
  endtask

  task automatic do_read(input logic [7:0] addr, input int n);
    logic ack;
    logic [7:0] d;
    i2c_start();
    send_byte(8'h90, ack); chk("rd_addr_ack", ack, 1'b0);
    send_byte(addr, ack);  chk("rd_ptr_ack", ack, 1'b0);
    model_ptr = addr;
    i2c_start();
    send_byte(8'h91, ack); chk("rd_raddr_ack", ack, 1'b0);
    for (int i = 0; i < n; i++) begin
      recv_byte((i == n - 1) ? 1'b1 : 1'b0, d);
      chk("rd_data", d, model_mem[model_ptr]);
      if (i != n - 1) model_ptr = model_ptr + 8'd1;
    end
    chk("rd_oe_after_nack", sda_oe, 1'b0);
    i2c_stop();
    chk("rd_ptr_end", reg_addr, model_ptr);
  endtask

  initial begin
    int we0, re0, oe0;
    logic ack;
    logic s;
    logic [7:0] d;
    total = 0; bad = 0;
    model_ptr = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[i]       = 8'(i) ^ 8'h3C;
      model_mem[i] = 8'(i) ^ 8'h3C;
    end
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    #32;
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_reg_addr", reg_addr, 8'h00);
    chk("rst_reg_wdata", reg_wdata, 8'h00);
    chk("rst_reg_we", reg_we, 1'b0);
    chk("rst_reg_re", reg_re, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    #50;

    // Directed write: 0x90, ptr 0x05, data 0xA5.
    we0 = we_cnt;
    i2c_start();
    send_byte(8'h90, ack); chk("w_addr_ack", ack, 1'b0);
    chk("w_busy", busy, 1'b1);
    send_byte(8'h05, ack); chk("w_ptr_ack", ack, 1'b0);
    send_byte(8'hA5, ack); chk("w_data_ack", ack, 1'b0);
    i2c_stop();
    model_mem[8'h05] = 8'hA5;
    model_ptr = 8'h06;
    chk("w_we_pulses", we_cnt - we0, 1);
    chk("w_we_addr", last_we_addr, 8'h05);
    chk("w_we_data", last_we_data, 8'hA5);
    chk("w_ptr_end", reg_addr, model_ptr);

    // Burst read across the pointer wrap.
    re0 = re_cnt;
    do_read(8'hFF, 2);
    chk("r_re_pulses", re_cnt - re0, 2);
    chk("r_wrap_ptr", reg_addr, 8'h00);

    // Wrong address is ignored entirely.
    we0 = we_cnt; re0 = re_cnt; oe0 = oe_cnt;
    i2c_start();
    send_byte(8'h92, ack); chk("na_addr_nack", ack, 1'b1);
    chk("na_busy", busy, 1'b0);
    send_byte(8'h11, ack); chk("na_data_nack", ack, 1'b1);
    i2c_stop();
    chk("na_oe_never", oe_cnt - oe0, 0);
    chk("na_no_we", we_cnt - we0, 0);
    chk("na_no_re", re_cnt - re0, 0);

    // STOP after four data bits discards the byte.
    we0 = we_cnt;
    i2c_start();
    send_byte(8'h90, ack); chk("ab_addr_ack", ack, 1'b0);
    send_byte(8'h10, ack); chk("ab_ptr_ack", ack, 1'b0);
    for (int i = 0; i < 4; i++) bit_cycle(1'b1, s);
    i2c_stop();
    chk("ab_no_we", we_cnt - we0, 0);
    do_write(8'h30, 1);

    // Randomized traffic against the model.
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 0)
        do_write(8'($urandom), int'($urandom_range(1, 4)));
      else
        do_read(8'($urandom), int'($urandom_range(1, 4)));
    end

    // Reset while the target pulls SDA low for read bit 0.
    do_write(8'h20, 0);
    i2c_start();
    send_byte(8'h90, ack); send_byte(8'h20, ack);
    mem[8'h20] = 8'h5A;
    i2c_start();
    send_byte(8'h91, ack); chk("rr_addr_ack", ack, 1'b0);
    for (int i = 7; i >= 1; i--) begin
      bit_cycle(1'b1, s);
      d[i] = s;
    end
    m_sda = 1'b1; #25;
    m_scl = 1'b1; #10;
    chk("rr_oe_bit0", sda_oe, 1'b1);
    rst = 1'b1; #1;
    chk("rr_oe_async", sda_oe, 1'b0);
    chk("rr_reg_addr", reg_addr, 8'h00);
    chk("rr_reg_wdata", reg_wdata, 8'h00);
    chk("rr_we_re", {reg_we, reg_re}, 2'b00);
    chk("rr_busy", busy, 1'b0);
    #14;
    m_scl = 1'b0; #25;
    rst = 1'b0;
    i2c_stop();

    chk("sda_stable_scl_high", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
